tone_sequencer: RTL and testbench

Controller that sequences the speaker square-wave datapath. It plays a programmable list of notes out of GPIO to the speaker. A small note table holds a half-period and a duration for each entry. On a start pulse the block steps through the table, drives the square wave at each note's pitch for that note's duration, and inserts a short silent gap between notes. The block sits between board controls (KEY) or a host and the GPIO speaker pin.

---
 rtl/tone_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_tone_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Note-table tone sequencer: plays (half-period, duration) entries as a square wave on the speaker pin.
// Optional macro SEQ_LOOP_EN: wrap to entry 0 at end of table instead of finishing with a done pulse.
module tone_sequencer #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 1000,
    parameter int DEPTH     = 16,
    parameter int PERIOD_W  = 20,
    parameter int DUR_W     = 12,
    parameter int GAP_TICKS = 10,
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                start,
    input  logic                stop,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [DUR_W-1:0]    wr_dur,
    output logic                speaker,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    note_idx,
    output logic [2:0]          state_dbg
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_LAST = (GAP_TICKS == 0) ? 0 : GAP_TICKS - 1;
    localparam bit GAP_ONE  = (GAP_TICKS == 0);
    localparam int ENTRY_W  = PERIOD_W + DUR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_PLAY  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [PERIOD_W-1:0] half_q, half_d;
    logic [DUR_W-1:0]    cnt_q, cnt_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                speaker_q, speaker_d;
    logic [ENTRY_W-1:0]  rd_data_q, rd_data_d;

    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic                wr_ok;
    logic                tick;
    logic                gap_end;
    logic [PERIOD_W-1:0] rd_period;
    logic [DUR_W-1:0]    rd_dur;

    assign wr_ok     = wr_en && (state_q == S_IDLE);
    assign rd_period = rd_data_q[ENTRY_W-1:DUR_W];
    assign rd_dur    = rd_data_q[DUR_W-1:0];

    // Read address is the index FETCH will see next cycle; a same-cycle write to it is forwarded.
    always_comb begin
        if (wr_ok && (wr_addr == idx_d)) begin
            rd_data_d = {wr_period, wr_dur};
        end else begin
            rd_data_d = mem[idx_d];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_ok) begin
            mem[wr_addr] <= {wr_period, wr_dur};
        end
        rd_data_q <= rd_data_d;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        period_d  = period_q;
        dur_d     = dur_q;
        half_d    = half_q;
        cnt_d     = cnt_q;
        tick_d    = tick_q;
        speaker_d = speaker_q;

        tick    = ((state_q == S_PLAY) || (state_q == S_GAP)) && (tick_q == TICK_W'(TICK_DIV - 1));
        gap_end = GAP_ONE || (tick && (cnt_q == DUR_W'(GAP_LAST)));

        if ((state_q == S_PLAY) || (state_q == S_GAP)) begin
            tick_d = tick ? '0 : tick_q + TICK_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end
            end
            S_FETCH: begin
                period_d = rd_period;
                dur_d    = rd_dur;
                if (rd_dur == '0) begin
`ifdef SEQ_LOOP_EN
                    // An end marker at entry 0 means an empty table: finish rather than spin.
                    if (idx_q != '0) begin
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d   = S_PLAY;
                    speaker_d = 1'b0;
                    half_d    = '0;
                    cnt_d     = '0;
                    tick_d    = '0;
                end
            end
            S_PLAY: begin
                if (period_q != '0) begin
                    if (half_q == period_q - PERIOD_W'(1)) begin
                        half_d    = '0;
                        speaker_d = ~speaker_q;
                    end else begin
                        half_d = half_q + PERIOD_W'(1);
                    end
                end
                if (tick) begin
                    if (cnt_q == dur_q - DUR_W'(1)) begin
                        state_d   = S_GAP;
                        speaker_d = 1'b0;
                        cnt_d     = '0;
                        tick_d    = '0;
                    end else begin
                        cnt_d = cnt_q + DUR_W'(1);
                    end
                end
            end
            S_GAP: begin
                speaker_d = 1'b0;
                if (gap_end) begin
                    if (idx_q == IDX_W'(DEPTH - 1)) begin
`ifdef SEQ_LOOP_EN
                        idx_d   = '0;
                        state_d = S_FETCH;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_FETCH;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q + DUR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every other transition, including a coincident start.
        if (stop && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            speaker_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            period_q  <= '0;
            dur_q     <= '0;
            half_q    <= '0;
            cnt_q     <= '0;
            tick_q    <= '0;
            speaker_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            period_q  <= period_d;
            dur_q     <= dur_d;
            half_q    <= half_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            speaker_q <= speaker_d;
        end
    end

    assign speaker   = speaker_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_PLAY) || (state_q == S_GAP);
    assign done      = (state_q == S_DONE);
    assign note_idx  = idx_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed and random note tables checked against a trace model.
// Honours SEQ_LOOP_EN when the design is built with it.
module tb_tone_sequencer;

    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 100;
    localparam int DEPTH     = 4;
    localparam int PERIOD_W  = 20;
    localparam int DUR_W     = 12;
    localparam int GAP_TICKS = 1;
    localparam int IDX_W     = 2;
    localparam int TICK_DIV  = CLK_HZ / TICK_HZ;
    localparam int GAP_LEN   = (GAP_TICKS == 0) ? 1 : GAP_TICKS * TICK_DIV;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b1;
    logic                start     = 1'b0;
    logic                stop      = 1'b0;
    logic                wr_en     = 1'b0;
    logic [IDX_W-1:0]    wr_addr   = '0;
    logic [PERIOD_W-1:0] wr_period = '0;
    logic [DUR_W-1:0]    wr_dur    = '0;
    logic                speaker;
    logic                busy;
    logic                done;
    logic [IDX_W-1:0]    note_idx;
    logic [2:0]          state_dbg;

    int vectors     = 0;
    int miscompares = 0;

    // Reference table and expected per-cycle {speaker, busy, done, note_idx}
    int         m_per [DEPTH];
    int         m_dur [DEPTH];
    logic [4:0] exp_q [$];

    tone_sequencer #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .DEPTH    (DEPTH),
        .PERIOD_W (PERIOD_W),
        .DUR_W    (DUR_W),
        .GAP_TICKS(GAP_TICKS)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .start    (start),
        .stop     (stop),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_period(wr_period),
        .wr_dur   (wr_dur),
        .speaker  (speaker),
        .busy     (busy),
        .done     (done),
        .note_idx (note_idx),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push(input logic spk, input logic bsy, input logic dn, input int idx);
        exp_q.push_back({spk, bsy, dn, IDX_W'(idx)});
    endfunction

    // Expected trace from the cycle after start: FETCH, dur*TICK_DIV play cycles, GAP_LEN gap cycles, ...
    task automatic build_trace(input int n);
        int idx = 0;
        bit fin = 1'b0;
        exp_q.delete();
        while (!fin && exp_q.size() < n) begin
            push(1'b0, 1'b1, 1'b0, idx);
            if (m_dur[idx] == 0) begin
`ifdef SEQ_LOOP_EN
                if (idx != 0) begin
                    idx = 0;
                    continue;
                end
`endif
                push(1'b0, 1'b0, 1'b1, idx);
                fin = 1'b1;
            end else begin
                for (int k = 0; k < m_dur[idx] * TICK_DIV; k++) begin
                    push((m_per[idx] != 0) && (((k / m_per[idx]) % 2) == 1), 1'b1, 1'b0, idx);
                end
                for (int k = 0; k < GAP_LEN; k++) begin
                    push(1'b0, 1'b1, 1'b0, idx);
                end
                if (idx == DEPTH - 1) begin
`ifdef SEQ_LOOP_EN
                    idx = 0;
`else
                    push(1'b0, 1'b0, 1'b1, idx);
                    fin = 1'b1;
`endif
                end else begin
                    idx++;
                end
            end
        end
        while (exp_q.size() < n) begin
            push(1'b0, 1'b0, 1'b0, idx);
        end
    endtask

    task automatic write_entry(input int a, input int per, input int dur, input bit upd);
        wr_en     = 1'b1;
        wr_addr   = IDX_W'(a);
        wr_period = PERIOD_W'(per);
        wr_dur    = DUR_W'(dur);
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (upd) begin
            m_per[a] = per;
            m_dur[a] = dur;
        end
    endtask

    // Pulse start (alongside any pending write) and compare n cycles against the model.
    task automatic play(input int n, input string tag);
        logic [4:0] obs;
        build_trace(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            obs = {speaker, busy, done, note_idx};
            check(tag, 32'(obs), 32'(exp_q.pop_front()));
            @(posedge clk); #1;
        end
    endtask

    task automatic halt();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("halt_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_speaker", 32'(speaker), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(note_idx), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single note followed by an end marker
        write_entry(0, 3, 2, 1'b1);
        for (int a = 1; a < DEPTH; a++) write_entry(a, 0, 0, 1'b1);
        play(40, "single");
        halt();

        // Rest note then a pitched note
        write_entry(0, 0, 1, 1'b1);
        write_entry(1, 2, 1, 1'b1);
        write_entry(2, 0, 0, 1'b1);
        play(50, "rest");
        halt();

        // Every entry used, no end marker
        for (int a = 0; a < DEPTH; a++) write_entry(a, a + 1, 1, 1'b1);
        play(100, "full");
        halt();

        // Write and start in the same cycle: FETCH must see the new entry 0
        wr_en = 1'b1; wr_addr = '0; wr_period = PERIOD_W'(4); wr_dur = DUR_W'(2);
        m_per[0] = 4; m_dur[0] = 2;
        play(110, "wr_start");
        halt();

        // A write while busy must be dropped
        play(15, "busy_wr_a");
        write_entry(0, 1, 3, 1'b0);
        repeat (150) @(posedge clk);
        #1;
        halt();
        play(110, "busy_wr_b");
        halt();

        // Stop (with a coincident start) in the middle of the second note
        write_entry(0, 1, 1, 1'b1);
        write_entry(1, 3, 1, 1'b1);
        write_entry(2, 2, 1, 1'b1);
        write_entry(3, 4, 1, 1'b1);
        play(26, "stop_run");
        stop = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0; start = 1'b0;
        check("stop_out", 32'({speaker, busy, done}), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("stop_idle", 32'({speaker, busy, done}), 32'd0);
        end

        // Asynchronous reset while speaker is high in the second note, then replay from retained table
        play(27, "rst_run");
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'({speaker, busy, done, note_idx}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        play(100, "rst_replay");
        halt();

        // Random tables
        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                write_entry(a, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b1);
            end
            play(180, "rand");
            halt();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
